// File: rtl/regfile_rdport_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdport_bank
// Description : DEPTH x WIDTH register file with one synchronous write port
//               and NUM_RD independent registered read ports. Each read port
//               has an enable/valid handshake and optional write-to-read
//               bypass. Register 0 can be hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport_bank #(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_err
);

    localparam bit C_ZERO_REG = (ZERO_REG != 0);
    localparam bit C_BYPASS   = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wr_err;
    logic             w_wr_ok;
    logic             w_wr_do;

    // A write target is legal when it exists and is not the hardwired zero register.
    always_comb begin
        w_wr_ok = (32'(wr_addr) < DEPTH) && !(C_ZERO_REG && (wr_addr == '0));
        w_wr_do = wr_en && w_wr_ok;
    end

    // Storage array; the zero register is never written, so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_do && (wr_addr == ADDR_W'(i))) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    end

    // Flag a dropped write for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [WIDTH-1:0]  w_result;
        logic [WIDTH-1:0]  r_data;
        logic              r_valid;

        assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Read result in priority order: out of range, zero register, bypass, stored value.
        always_comb begin
            w_result = '0;
            if (!(32'(w_addr) < DEPTH)) begin
                w_result = '0;
            end else if (C_ZERO_REG && (w_addr == '0)) begin
                w_result = '0;
            end else if (C_BYPASS && w_wr_do && (wr_addr == w_addr)) begin
                w_result = wr_data;
            end else begin
                w_result = r_mem[w_addr];
            end
        end

        // Capture on request; data holds and valid drops when the port is idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= rd_en[p];
                if (rd_en[p]) begin
                    r_data <= w_result;
                end
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = r_data;
        assign rd_valid[p]               = r_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_rdport_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_rdport_bank
// Description : Directed self-checking bench for regfile_rdport_bank. Four
//               instances share one stimulus bus: default parameters, no
//               bypass, no zero register, and DEPTH=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_rdport_bank;

    localparam int C_W  = 16;
    localparam int C_AW = 3;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [C_AW-1:0] wr_addr;
    logic [C_W-1:0]  wr_data;
    logic [1:0]      rd_en;
    logic [2*C_AW-1:0] rd_addr;

    logic [2*C_W-1:0] d_data,  nb_data,  nz_data,  s6_data;
    logic [1:0]       d_valid, nb_valid, nz_valid, s6_valid;
    logic             d_err,   nb_err,   nz_err,   s6_err;

    int checks = 0;
    int errors = 0;

    regfile_rdport_bank u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d_data), .rd_valid(d_valid), .wr_err(d_err)
    );

    regfile_rdport_bank #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(nb_data), .rd_valid(nb_valid), .wr_err(nb_err)
    );

    regfile_rdport_bank #(.ZERO_REG(0)) u_nozero (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(nz_data), .rd_valid(nz_valid), .wr_err(nz_err)
    );

    regfile_rdport_bank #(.DEPTH(6)) u_d6 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s6_data), .rd_valid(s6_valid), .wr_err(s6_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [C_AW-1:0] wa, input logic [C_W-1:0] wd,
                         input logic [1:0] re, input logic [C_AW-1:0] ra0, input logic [C_AW-1:0] ra1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = {ra1, ra0};
    endtask

    task automatic test_reset();
        drive(1'b1, 3'd3, 16'hBEEF, 2'b00, 3'd0, 3'd0);
        tick();
        // Illegal r0 write plus a read so every output is nonzero before reset.
        drive(1'b1, 3'd0, 16'h7777, 2'b01, 3'd3, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'hBEEF || d_valid !== 2'b01 || d_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: data=%h valid=%b err=%b expected data=beef valid=01 err=1",
                     d_data[15:0], d_valid, d_err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (d_data !== 32'h0 || d_valid !== 2'b00 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: data=%h valid=%b err=%b expected 0/00/0", d_data, d_valid, d_err);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0);
        #10 rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd3, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'h0000 || d_valid !== 2'b01) begin
            errors++;
            $display("FAIL reset_r3_cleared: data=%h valid=%b expected 0000/01", d_data[15:0], d_valid);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 3'd5, 16'h1234, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 2'b11, 3'd5, 3'd5);
        tick();
        checks++;
        if (d_data !== 32'h1234_1234 || d_valid !== 2'b11) begin
            errors++;
            $display("FAIL basic_rw: data=%h valid=%b expected 12341234/11", d_data, d_valid);
        end
        checks++;
        if (d_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_err: err=%b expected 0", d_err);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 3'd2, 16'h0001, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd2, 16'hA5A5, 2'b01, 3'd2, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_on: data=%h expected a5a5", d_data[15:0]);
        end
        checks++;
        if (nb_data[15:0] !== 16'h0001) begin
            errors++;
            $display("FAIL bypass_off: data=%h expected 0001", nb_data[15:0]);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd2, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'hA5A5 || nb_data[15:0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_after: data=%h/%h expected a5a5/a5a5", d_data[15:0], nb_data[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 3'd0, 16'hFFFF, 2'b10, 3'd0, 3'd0);
        tick();
        checks++;
        if (d_data[31:16] !== 16'h0000 || d_valid !== 2'b10 || d_err !== 1'b1) begin
            errors++;
            $display("FAIL zero_write: data=%h valid=%b err=%b expected 0000/10/1",
                     d_data[31:16], d_valid, d_err);
        end
        checks++;
        if (nz_err !== 1'b0) begin
            errors++;
            $display("FAIL nozero_err: err=%b expected 0", nz_err);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b10, 3'd0, 3'd0);
        tick();
        checks++;
        if (d_data[31:16] !== 16'h0000 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_later: data=%h err=%b expected 0000/0", d_data[31:16], d_err);
        end
        checks++;
        if (nz_data[31:16] !== 16'hFFFF || nz_err !== 1'b0) begin
            errors++;
            $display("FAIL nozero_read: data=%h err=%b expected ffff/0", nz_data[31:16], nz_err);
        end
    endtask

    task automatic test_out_of_range();
        logic [C_W-1:0] exp_mem [6];
        exp_mem = '{16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 16'h1234};
        drive(1'b1, 3'd7, 16'h5555, 2'b00, 3'd0, 3'd0);
        tick();
        checks++;
        if (s6_err !== 1'b1 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr_err: d6 err=%b d8 err=%b expected 1/0", s6_err, d_err);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'd0, 16'h0, 2'b01, C_AW'(i), 3'd0);
            tick();
            checks++;
            if (s6_data[15:0] !== exp_mem[i]) begin
                errors++;
                $display("FAIL oor_unchanged r%0d: data=%h expected %h", i, s6_data[15:0], exp_mem[i]);
            end
        end
        checks++;
        if (s6_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear: err=%b expected 0", s6_err);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b11, 3'd5, 3'd6);
        tick();
        checks++;
        if (s6_data !== 32'h0000_1234 || s6_valid !== 2'b11) begin
            errors++;
            $display("FAIL oor_read: data=%h valid=%b expected 00001234/11", s6_data, s6_valid);
        end
    endtask

    task automatic test_hold_valid();
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd5, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'h1234 || d_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_first: data=%h valid=%b expected 1234/1", d_data[15:0], d_valid[0]);
        end
        drive(1'b1, 3'd5, 16'h9999, 2'b00, 3'd5, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd5, 3'd0);
            checks++;
            if (d_data[15:0] !== 16'h1234 || d_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle%0d: data=%h valid=%b expected 1234/0", i, d_data[15:0], d_valid[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd5, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'h9999 || d_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: data=%h valid=%b expected 9999/1", d_data[15:0], d_valid[0]);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b01, 3'd2, 3'd0);
        tick();
        checks++;
        if (d_data[15:0] !== 16'hA5A5 || d_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: data=%h valid=%b expected a5a5/1", d_data[15:0], d_valid[0]);
        end
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0);
        tick();
        checks++;
        if (d_valid !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: valid=%b expected 00", d_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0);
        #23 rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_out_of_range();
        test_hold_valid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
